// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master: state encoding,
// quarter-bit phase names and default widths.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_ADDR      = 4'd2,
    ST_ADDR_ACK  = 4'd3,
    ST_WRITE     = 4'd4,
    ST_WRITE_ACK = 4'd5,
    ST_READ      = 4'd6,
    ST_MACK      = 4'd7,
    ST_STOP      = 4'd8,
    ST_DONE      = 4'd9
  } state_t;

  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_HIGH   = 2'd1;
  localparam logic [1:0] PH_SAMPLE = 2'd2;
  localparam logic [1:0] PH_LOW    = 2'd3;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-bit phase counter and 3-bit bit counter; the bit counter only
// advances in byte-carrying states and wraps 7->0 at the byte end.
module i2c_bit_timer
  import i2c_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       cnt_en_i,
  output logic [1:0] phase_o,
  output logic [2:0] bit_cnt_o,
  output logic       slot_end_o,
  output logic       byte_end_o
);

  logic [1:0] phase_q;
  logic [2:0] bit_q;

  assign phase_o    = phase_q;
  assign bit_cnt_o  = bit_q;
  assign slot_end_o = tick_i && (phase_q == PH_LOW);
  assign byte_end_o = slot_end_o && cnt_en_i && (bit_q == 3'd7);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= PH_SETUP;
      bit_q   <= 3'd0;
    end else begin
      if (tick_i) begin
        phase_q <= phase_q + 2'd1;
      end
      if (slot_end_o && cnt_en_i) begin
        bit_q <= bit_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master sequencer: START, address+R/W, ACK, one data byte,
// ACK/NACK, STOP. Bus levels are registered from the current state/phase.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int ADDR_W_P = i2c_pkg::ADDR_W,
  parameter int DATA_W_P = i2c_pkg::DATA_W
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                qtick,
  output logic                presc_en,
  input  logic                start,
  input  logic [ADDR_W_P-1:0] addr,
  input  logic                rw,
  input  logic [DATA_W_P-1:0] wdata,
  output logic [DATA_W_P-1:0] rdata,
  output logic                busy,
  output logic                done,
  output logic                ack_err,
  output logic                scl_o,
  output logic                sda_oe,
  input  logic                sda_i
);

  state_t              state_q;
  logic [ADDR_W_P-1:0] addr_q;
  logic                rw_q;
  logic [DATA_W_P-1:0] wdata_q;
  logic [DATA_W_P-1:0] rx_q;
  logic [DATA_W_P-1:0] rdata_q;
  logic                busy_q, done_q, ack_err_q, presc_en_q, scl_q, sda_oe_q;

  logic [1:0] phase_s;
  logic [2:0] bit_s;
  logic       tick_s, slot_end_s, byte_end_s, cnt_en_s, sample_s;
  logic       tx_bit_s, scl_mid_s, scl_d, sda_oe_d;
  logic [ADDR_W_P:0] addr_byte_s;

  assign tick_s      = qtick && presc_en_q;
  assign sample_s    = tick_s && (phase_s == PH_SAMPLE);
  assign cnt_en_s    = (state_q == ST_ADDR) || (state_q == ST_WRITE) || (state_q == ST_READ);
  assign addr_byte_s = {addr_q, rw_q};
  assign scl_mid_s   = (phase_s == PH_HIGH) || (phase_s == PH_SAMPLE);

  assign presc_en = presc_en_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign scl_o    = scl_q;
  assign sda_oe   = sda_oe_q;

  i2c_bit_timer u_timer (
    .clk_i      (sys_clk),
    .rst_i      (reset),
    .tick_i     (tick_s),
    .cnt_en_i   (cnt_en_s),
    .phase_o    (phase_s),
    .bit_cnt_o  (bit_s),
    .slot_end_o (slot_end_s),
    .byte_end_o (byte_end_s)
  );

  always_comb begin
    tx_bit_s = 1'b1;
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_q)
      ST_ADDR:  tx_bit_s = addr_byte_s[3'd7 - bit_s];
      ST_WRITE: tx_bit_s = wdata_q[3'd7 - bit_s];
      default:  tx_bit_s = 1'b1;
    endcase
    case (state_q)
      ST_START: begin
        scl_d    = (phase_s != PH_LOW);
        sda_oe_d = phase_s[1];
      end
      ST_ADDR, ST_WRITE: begin
        scl_d    = scl_mid_s;
        sda_oe_d = ~tx_bit_s;
      end
      ST_ADDR_ACK, ST_WRITE_ACK, ST_READ, ST_MACK: begin
        scl_d    = scl_mid_s;
        sda_oe_d = 1'b0;
      end
      // SDA low under low SCL, raise SCL, then release SDA for the STOP edge
      ST_STOP: begin
        scl_d    = (phase_s != PH_SETUP);
        sda_oe_d = ~phase_s[1];
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      presc_en_q <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
    end else begin
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q     <= addr;
            rw_q       <= rw;
            wdata_q    <= wdata;
            busy_q     <= 1'b1;
            presc_en_q <= 1'b1;
            ack_err_q  <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: if (slot_end_s) state_q <= ST_ADDR;
        ST_ADDR:  if (byte_end_s) state_q <= ST_ADDR_ACK;
        ST_ADDR_ACK: begin
          if (sample_s && sda_i) ack_err_q <= 1'b1;
          if (slot_end_s) state_q <= ack_err_q ? ST_STOP : (rw_q ? ST_READ : ST_WRITE);
        end
        ST_WRITE: if (byte_end_s) state_q <= ST_WRITE_ACK;
        ST_WRITE_ACK: begin
          if (sample_s && sda_i) ack_err_q <= 1'b1;
          if (slot_end_s) state_q <= ST_STOP;
        end
        ST_READ: begin
          if (sample_s) rx_q <= {rx_q[DATA_W_P-2:0], sda_i};
          if (byte_end_s) begin
            rdata_q <= rx_q;
            state_q <= ST_MACK;
          end
        end
        ST_MACK: if (slot_end_s) state_q <= ST_STOP;
        ST_STOP: begin
          if (slot_end_s) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q     <= 1'b0;
          presc_en_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          busy_q     <= 1'b0;
          presc_en_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
